vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_timing_gen_lock_sync.sv | 23 ++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: default 640x480@60
// timing, total derivation, raster state encoding and the colour-bar table.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 4:4:4 colour for each of the eight vertical bars, left to right
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] colour;
    case (idx)
      3'd0:    colour = 12'hFFF;
      3'd1:    colour = 12'hFF0;
      3'd2:    colour = 12'h0FF;
      3'd3:    colour = 12'h0F0;
      3'd4:    colour = 12'hF0F;
      3'd5:    colour = 12'hF00;
      3'd6:    colour = 12'h00F;
      default: colour = 12'h000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_timing_gen_lock_sync.sv
// Two-flop synchroniser with synchronous reset, usable for any slow
// asynchronous level such as a PLL lock flag.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_level,
  output logic sync_level
);

  logic meta_r;

  // Two-stage capture of the asynchronous level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r     <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      meta_r     <= async_level;
      sync_level <= meta_r;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator gated by PLL lock; optional colour-bar pattern on
// rgb is enabled with the macro VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [11:0]   rgb
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          lock_s;
  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] v_cnt_r;
  logic          hsync_act_s;
  logic          vsync_act_s;
  logic          de_s;

  lock_sync u_lock_sync (
    .clk         (clk),
    .rst         (rst),
    .async_level (pll_locked),
    .sync_level  (lock_s)
  );

  // Raster state follows the synchronised lock; the clock entering RUN decodes (0,0)
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (lock_s) state_next_s = RUN;
        else        state_next_s = IDLE;
      end
      RUN: begin
        if (lock_s) state_next_s = RUN;
        else        state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Region decode of the current counter position
  always_comb begin
    hsync_act_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vsync_act_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    de_s        = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  end

  // Counters and registered timing outputs; leaving RUN zeroes the raster
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      h_cnt_r     <= {CW{1'b0}};
      v_cnt_r     <= {CW{1'b0}};
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= {CW{1'b0}};
      y           <= {CW{1'b0}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (state_next_s == RUN) begin
      state_r     <= state_next_s;
      hsync       <= hsync_act_s ? SYNC_POL : ~SYNC_POL;
      vsync       <= vsync_act_s ? SYNC_POL : ~SYNC_POL;
      de          <= de_s;
      x           <= de_s ? h_cnt_r : {CW{1'b0}};
      y           <= de_s ? v_cnt_r : {CW{1'b0}};
      line_start  <= (h_cnt_r == {CW{1'b0}});
      frame_start <= (h_cnt_r == {CW{1'b0}}) && (v_cnt_r == {CW{1'b0}});
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= {CW{1'b0}};
        v_cnt_r <= (v_cnt_r == V_LAST) ? {CW{1'b0}} : v_cnt_r + CW'(1);
      end else begin
        h_cnt_r <= h_cnt_r + CW'(1);
        v_cnt_r <= v_cnt_r;
      end
    end else begin
      state_r     <= state_next_s;
      h_cnt_r     <= {CW{1'b0}};
      v_cnt_r     <= {CW{1'b0}};
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= {CW{1'b0}};
      y           <= {CW{1'b0}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar_idx_s;
  logic [11:0] rgb_r;

  // Bar number is the column divided by the bar width
  always_comb begin
    bar_idx_s = 3'(h_cnt_r / CW'(BAR_W));
  end

  // Pattern colour registered alongside de, black in blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 12'h000;
    end else if ((state_next_s == RUN) && de_s) begin
      rgb_r <= bar_colour(bar_idx_s);
    end else begin
      rgb_r <= 12'h000;
    end
  end

  assign rgb = rgb_r;
`else
  assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for reset/lock/line checks and a
// reduced-timing instance for full-frame, wrap and lock-drop checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst = 1'b1;
  logic locked_a = 1'b1;
  logic locked_b = 1'b1;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [11:0] rgb_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [11:0] rgb_b;

  int total = 0;
  int bad   = 0;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst), .pll_locked(locked_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .rgb(rgb_a)
  );

  // Small raster: H 16+2+4+2=24, V 6+1+2+1=10, frame 240 clocks
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pll_locked(locked_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .rgb(rgb_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_a = 1'b1; locked_b = 1'b1;
    repeat (5) tick();
    total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hs_a); end
    total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vs_a); end
    total++; if (de_a !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", de_a); end
    total++; if (x_a !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", x_a); end
    total++; if (y_a !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", y_a); end
    total++; if (ls_a !== 1'b0) begin bad++; $display("FAIL reset_line_start got=%b exp=0", ls_a); end
    total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b exp=0", fs_a); end
    total++; if (rgb_a !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", rgb_a); end
    total++; if (hs_b !== 1'b1 || vs_b !== 1'b1) begin bad++; $display("FAIL reset_sync_b got=%b%b exp=11", hs_b, vs_b); end
    total++; if (de_b !== 1'b0 || fs_b !== 1'b0 || rgb_b !== 12'h000) begin bad++; $display("FAIL reset_b got de=%b fs=%b rgb=%h exp 0", de_b, fs_b, rgb_b); end
  endtask

  task automatic test_lock_sync();
    int n = 0;
    rst = 1'b0;
    while (fs_a !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL lock_latency got=%0d exp=3", n); end
    total++; if (de_a !== 1'b1) begin bad++; $display("FAIL first_de got=%b exp=1", de_a); end
    total++; if (x_a !== 10'd0 || y_a !== 10'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d exp=0,0", x_a, y_a); end
    total++; if (ls_a !== 1'b1) begin bad++; $display("FAIL first_line_start got=%b exp=1", ls_a); end
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL first_frame_b got=%b exp=1", fs_b); end
  endtask

  // Walk from frame_start through one full line plus the next line start
  task automatic test_line_timing();
    for (int k = 0; k <= 800; k++) begin
      int h = k % 800;
      int ln = k / 800;
      logic de_e = (h < 640);
      logic hs_e = !((h >= 656) && (h < 752));
      logic [9:0] x_e = de_e ? 10'(h) : 10'd0;
      logic [9:0] y_e = de_e ? 10'(ln) : 10'd0;
      logic rgb_chk = 1'b1;
      logic [11:0] rgb_e = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (h == 0) rgb_e = 12'hFFF;
      else if (h == 80) rgb_e = 12'hFF0;
      else if (h == 639) rgb_e = 12'h000;
      else if (h >= 640) rgb_e = 12'h000;
      else rgb_chk = 1'b0;
`endif
      total++; if (de_a !== de_e) begin bad++; $display("FAIL line_de k=%0d got=%b exp=%b", k, de_a, de_e); end
      total++; if (hs_a !== hs_e) begin bad++; $display("FAIL line_hsync k=%0d got=%b exp=%b", k, hs_a, hs_e); end
      total++; if (ls_a !== (h == 0)) begin bad++; $display("FAIL line_start k=%0d got=%b exp=%b", k, ls_a, (h == 0)); end
      total++; if (x_a !== x_e || y_a !== y_e) begin bad++; $display("FAIL line_xy k=%0d got=%0d,%0d exp=%0d,%0d", k, x_a, y_a, x_e, y_e); end
      total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL line_vsync k=%0d got=%b exp=1", k, vs_a); end
      if (rgb_chk) begin
        total++; if (rgb_a !== rgb_e) begin bad++; $display("FAIL line_rgb k=%0d got=%h exp=%h", k, rgb_a, rgb_e); end
      end
      if (k < 800) tick();
    end
  endtask

  // Measure one small frame from frame_start to the next
  task automatic measure_frame_b(input string tag, output int k);
    int de_cnt = 0;
    int vs_cnt = 0;
    int vs_first = -1;
    k = 0;
    do begin
      if (de_b === 1'b1) de_cnt++;
      if (vs_b === 1'b0) begin
        if (vs_first < 0) vs_first = k;
        vs_cnt++;
      end
      tick();
      k++;
    end while (fs_b !== 1'b1 && k < 300);
    total++; if (k !== 240) begin bad++; $display("FAIL %s_period got=%0d exp=240", tag, k); end
    total++; if (de_cnt !== 96) begin bad++; $display("FAIL %s_de_count got=%0d exp=96", tag, de_cnt); end
    total++; if (vs_cnt !== 48) begin bad++; $display("FAIL %s_vsync_len got=%0d exp=48", tag, vs_cnt); end
    total++; if (vs_first !== 168) begin bad++; $display("FAIL %s_vsync_start got=%0d exp=168", tag, vs_first); end
  endtask

  task automatic test_frame_timing();
    int n = 0;
    int per;
    while (fs_b !== 1'b1 && n < 300) begin tick(); n++; end
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL frame_sync_wait got=%b exp=1", fs_b); end
    measure_frame_b("frame", per);
    total++; if (x_b !== 10'd0 || y_b !== 10'd0 || de_b !== 1'b1) begin bad++; $display("FAIL wrap_xy got=%0d,%0d de=%b exp=0,0 de=1", x_b, y_b, de_b); end
    total++; if (ls_b !== 1'b1) begin bad++; $display("FAIL wrap_line_start got=%b exp=1", ls_b); end
  endtask

  task automatic test_lock_drop();
    int n = 0;
    int per;
    repeat (77) tick();
    total++; if (x_b !== 10'd5 || y_b !== 10'd3) begin bad++; $display("FAIL drop_pos got=%0d,%0d exp=5,3", x_b, y_b); end
    locked_b = 1'b0;
    repeat (3) tick();
    total++; if (de_b !== 1'b0 || x_b !== 10'd0 || y_b !== 10'd0) begin bad++; $display("FAIL drop_idle got de=%b xy=%0d,%0d exp de=0 xy=0,0", de_b, x_b, y_b); end
    total++; if (hs_b !== 1'b1 || vs_b !== 1'b1 || ls_b !== 1'b0 || fs_b !== 1'b0) begin bad++; $display("FAIL drop_sync got hs=%b vs=%b ls=%b fs=%b exp 1100", hs_b, vs_b, ls_b, fs_b); end
    repeat (10) tick();
    total++; if (de_b !== 1'b0 || fs_b !== 1'b0) begin bad++; $display("FAIL drop_hold got de=%b fs=%b exp 00", de_b, fs_b); end
    locked_b = 1'b1;
    while (fs_b !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL relock_latency got=%0d exp=3", n); end
    total++; if (x_b !== 10'd0 || y_b !== 10'd0 || de_b !== 1'b1) begin bad++; $display("FAIL relock_xy got=%0d,%0d de=%b exp=0,0 de=1", x_b, y_b, de_b); end
    measure_frame_b("relock1", per);
    measure_frame_b("relock2", per);
  endtask

  initial begin
    test_reset();
    test_lock_sync();
    test_line_timing();
    test_frame_timing();
    test_lock_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
